// File: rtl/seq_addr_counter_pkg.sv
// Shared definitions for the sequence-game address counter: FSM encoding,
// default widths and counting-direction constants.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DWELL_W = 8;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : seq_pkg

// File: rtl/seq_addr_counter_if.sv
// Control/status bundle between the game FSM (master) and the address
// counter (slave); the counter's address output feeds the sequence ROM.
interface seq_addr_counter_if #(
    parameter int ADDR_W  = 4,
    parameter int DWELL_W = 8
) ();

    logic               start;
    logic               E;
    logic               dir;
    logic [ADDR_W-1:0]  limit;
    logic [DWELL_W-1:0] dwell;
    logic [ADDR_W-1:0]  SEQFPGA;
    logic               valid;
    logic               step;
    logic               tc;

    modport master (
        output start, E, dir, limit, dwell,
        input  SEQFPGA, valid, step, tc
    );

    modport slave (
        input  start, E, dir, limit, dwell,
        output SEQFPGA, valid, step, tc
    );

endinterface : seq_addr_counter_if

// File: rtl/seq_addr_counter_dwell_timer.sv
// Down-counter that sets how many cycles each address is held; the zero
// flag tells the address FSM that the current dwell has expired.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule : dwell_timer

// File: rtl/seq_addr_counter.sv
// Round-address generator: walks 0..limit or limit..0, holding each address
// for a programmable dwell, with pause, stop-at-end or auto-wrap.
module seq_addr_counter
    import seq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DWELL_W   = DEF_DWELL_W,
    parameter bit WRAP_MODE = 1'b0
) (
    input  logic clk,
    input  logic R,
    seq_addr_counter_if.slave bus
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [ADDR_W-1:0]  lim_q,   lim_d;
    logic               dir_q,   dir_d;
    logic [DWELL_W-1:0] dw_q,    dw_d;
    logic               valid_q, valid_d;
    logic               step_q,  step_d;
    logic               tc_q,    tc_d;

    logic               tmr_load;
    logic               tmr_en;
    logic [DWELL_W-1:0] tmr_load_val;
    logic               tmr_zero;

    logic [DWELL_W-1:0] dw_eff;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W-1:0]  end_addr;

    // A zero dwell would make the timer meaningless; treat it as one cycle.
    assign dw_eff     = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign start_addr = (dir_q == DIR_DOWN) ? lim_q : '0;
    assign end_addr   = (dir_q == DIR_UP)   ? lim_q : '0;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (R),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lim_d        = lim_q;
        dir_d        = dir_q;
        dw_d         = dw_q;
        valid_d      = valid_q;
        step_d       = 1'b0;
        tc_d         = tc_q;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        tmr_load_val = dw_q - DWELL_W'(1);

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    lim_d        = bus.limit;
                    dir_d        = bus.dir;
                    dw_d         = dw_eff;
                    addr_d       = (bus.dir == DIR_DOWN) ? bus.limit : '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = dw_eff - DWELL_W'(1);
                    step_d       = 1'b1;
                    valid_d      = 1'b1;
                    tc_d         = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                tc_d = 1'b0;
                if (bus.E) begin
                    if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else if (addr_q != end_addr) begin
                        // End is compared before stepping, so no wrap arithmetic occurs.
                        addr_d   = (dir_q == DIR_DOWN) ? addr_q - ADDR_W'(1)
                                                       : addr_q + ADDR_W'(1);
                        tmr_load = 1'b1;
                        step_d   = 1'b1;
                    end else if (WRAP_MODE) begin
                        addr_d   = start_addr;
                        tmr_load = 1'b1;
                        step_d   = 1'b1;
                        tc_d     = 1'b1;
                    end else begin
                        valid_d  = 1'b0;
                        tc_d     = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                tc_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            lim_q   <= '0;
            dir_q   <= DIR_UP;
            dw_q    <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            dw_q    <= dw_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.SEQFPGA = addr_q;
    assign bus.valid   = valid_q;
    assign bus.step    = step_q;
    assign bus.tc      = tc_q;

endmodule : seq_addr_counter

// File: tb/tb_seq_addr_counter.sv
// Directed bench for seq_addr_counter: one stop-at-end instance and one
// auto-wrap instance, compared against hand-computed address sequences.
module tb_seq_addr_counter;

    localparam int ADDR_W  = 4;
    localparam int DWELL_W = 8;

    logic clk;
    logic R;

    int checks;
    int errors;

    seq_addr_counter_if #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) bus0 ();
    seq_addr_counter_if #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) bus1 ();

    seq_addr_counter #(
        .ADDR_W    (ADDR_W),
        .DWELL_W   (DWELL_W),
        .WRAP_MODE (1'b0)
    ) dut_stop (
        .clk (clk),
        .R   (R),
        .bus (bus0.slave)
    );

    seq_addr_counter #(
        .ADDR_W    (ADDR_W),
        .DWELL_W   (DWELL_W),
        .WRAP_MODE (1'b1)
    ) dut_wrap (
        .clk (clk),
        .R   (R),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start0(input logic [3:0] lim, input logic d, input logic [7:0] dw);
        bus0.limit = lim;
        bus0.dir   = d;
        bus0.dwell = dw;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    task automatic chk0(input string tag, input int addr, input bit v, input bit st, input bit t);
        check({tag, ".addr"},  32'(bus0.SEQFPGA), 32'(addr));
        check({tag, ".valid"}, 32'(bus0.valid),   32'(v));
        check({tag, ".step"},  32'(bus0.step),    32'(st));
        check({tag, ".tc"},    32'(bus0.tc),      32'(t));
    endtask

    int exp_a4 [11];
    bit exp_s4 [11];

    initial begin
        checks = 0;
        errors = 0;
        R = 1'b0;
        bus0.start = 1'b0; bus0.E = 1'b1; bus0.dir = 1'b0; bus0.limit = '0; bus0.dwell = '0;
        bus1.start = 1'b0; bus1.E = 1'b1; bus1.dir = 1'b0; bus1.limit = '0; bus1.dwell = '0;
        #12;
        chk0("reset", 0, 1'b0, 1'b0, 1'b0);
        tick();
        R = 1'b1;
        tick();
        chk0("idle", 0, 1'b0, 1'b0, 1'b0);

        // Test 1: asynchronous reset while the sequence sits on address 2
        start0(4'd3, 1'b0, 8'd2);
        for (int i = 0; i < 4; i++) tick();
        check("t1.pre_addr", 32'(bus0.SEQFPGA), 32'd2);
        #2;
        R = 1'b0;
        #1;
        chk0("t1.async", 0, 1'b0, 1'b0, 1'b0);
        tick();
        R = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk0("t1.idle", 0, 1'b0, 1'b0, 1'b0);

        // Test 2: up count, dwell 2
        start0(4'd3, 1'b0, 8'd2);
        for (int i = 0; i < 8; i++) begin
            chk0($sformatf("t2.c%0d", i), i / 2, 1'b1, (i % 2) == 0, 1'b0);
            tick();
        end
        chk0("t2.done", 3, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk0("t2.sticky", 3, 1'b0, 1'b0, 1'b1);

        // Test 3: down count, dwell 1, then restart from DONE
        start0(4'd5, 1'b1, 8'd1);
        for (int i = 0; i < 6; i++) begin
            chk0($sformatf("t3.c%0d", i), 5 - i, 1'b1, 1'b1, 1'b0);
            tick();
        end
        chk0("t3.done", 0, 1'b0, 1'b0, 1'b1);
        start0(4'd1, 1'b0, 8'd1);
        chk0("t3.r0", 0, 1'b1, 1'b1, 1'b0);
        tick();
        chk0("t3.r1", 1, 1'b1, 1'b1, 1'b0);
        tick();
        chk0("t3.rdone", 1, 1'b0, 1'b0, 1'b1);

        // Test 4: pause for 3 cycles at address 2; RUN stretches to 11 cycles
        exp_a4 = '{0, 0, 1, 1, 2, 2, 2, 2, 2, 3, 3};
        exp_s4 = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0};
        start0(4'd3, 1'b0, 8'd2);
        for (int i = 0; i < 11; i++) begin
            chk0($sformatf("t4.c%0d", i), exp_a4[i], 1'b1, exp_s4[i], 1'b0);
            bus0.E = !(i >= 4 && i <= 6);
            tick();
        end
        bus0.E = 1'b1;
        chk0("t4.done", 3, 1'b0, 1'b0, 1'b1);

        // Test 5a: dwell 0 is treated as 1, limit 0 gives a single address
        start0(4'd0, 1'b0, 8'd0);
        chk0("t5.c0", 0, 1'b1, 1'b1, 1'b0);
        tick();
        chk0("t5.done", 0, 1'b0, 1'b0, 1'b1);

        // Test 5b: start during RUN is ignored
        start0(4'd2, 1'b0, 8'd1);
        chk0("t5b.c0", 0, 1'b1, 1'b1, 1'b0);
        bus0.limit = 4'd7;
        bus0.dir   = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        chk0("t5b.c1", 1, 1'b1, 1'b1, 1'b0);
        tick();
        chk0("t5b.c2", 2, 1'b1, 1'b1, 1'b0);
        tick();
        chk0("t5b.done", 2, 1'b0, 1'b0, 1'b1);

        // Test 6: wrap instance, tc pulses on each return to address 0
        bus1.limit = 4'd2;
        bus1.dir   = 1'b0;
        bus1.dwell = 8'd1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6.c%0d.addr", i), 32'(bus1.SEQFPGA), 32'(i % 3));
            check($sformatf("t6.c%0d.valid", i), 32'(bus1.valid), 32'd1);
            check($sformatf("t6.c%0d.step", i), 32'(bus1.step), 32'd1);
            check($sformatf("t6.c%0d.tc", i), 32'(bus1.tc), 32'((i > 0) && (i % 3 == 0)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_addr_counter

// File: doc/seq_addr_counter.md
Name: seq_addr_counter

Overview:
Parametrised successor to the round-address counter of the sequence game. It generates the ROM address sequence for one round (0..limit, or limit..0), holding each address for a programmable dwell time. It supports pause, stop-at-end or auto-wrap, and a sticky or pulsed terminal flag. It sits between the game control FSM and the sequence ROM, and paces LED playback.

Parameters:
ADDR_W, 4, width of address and limit (max sequence length 2^ADDR_W)
DWELL_W, 8, width of the dwell-time field in clock cycles
WRAP_MODE, 0, 0 = stop in DONE at end; 1 = reload start address and keep running

Ports:
clk  in  1  system clock, rising edge
R  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request; latches limit/dir/dwell and begins a sequence
E  in  1  enable; 0 freezes address and dwell timer (pause)
dir  in  1  0 = count up 0..limit; 1 = count down limit..0
limit  in  ADDR_W  last address of the round (round number)
dwell  in  DWELL_W  cycles each address is held; 0 treated as 1
SEQFPGA  out  ADDR_W  current ROM address
valid  out  1  high while in RUN
step  out  1  one-cycle pulse in the first cycle each new address is presented
tc  out  1  terminal count: sticky in DONE (WRAP_MODE=0); one-cycle pulse per wrap (WRAP_MODE=1)

Behaviour:
- Reset (R=0, async): state IDLE; SEQFPGA=0, valid=0, step=0, tc=0; latched limit/dir/dwell cleared. Takes effect immediately, including mid-RUN.
- All outputs registered.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start=1 (E ignored for start):
  - latch lim=limit, d=dir, dw_eff = max(dwell,1).
  - SEQFPGA <= (d ? lim : 0); dwell timer <= dw_eff-1.
  - step <= 1, valid <= 1, tc <= 0; go to RUN.
- start during RUN: ignored.
- RUN, E=0: SEQFPGA, dwell timer and state hold; step=0.
- RUN, E=1, timer != 0: timer decrements; step=0.
- RUN, E=1, timer == 0:
  - If SEQFPGA != end (end = lim when up, 0 when down): address ±1 (no wrap arithmetic needed), timer reloaded, step=1.
  - Else, WRAP_MODE=0: go to DONE, valid=0, tc=1 (sticky), SEQFPGA holds last address.
  - Else, WRAP_MODE=1: reload start address, timer reloaded, step=1, tc=1 for that one cycle; stay in RUN.
- Latency: with E held high, RUN lasts exactly (lim+1)*dw_eff cycles. valid and the first address appear the cycle after start is sampled.
- limit=0: a single address 0 for dw_eff cycles, then end.
- limit=2^ADDR_W-1: full range, no overflow; comparison is on end, never on wrap.
- DONE: outputs hold until start or reset.
- step is never high in IDLE or DONE.

Decomposition:
- Shared package seq_pkg:
  - state encoding localparams (ST_IDLE, ST_RUN, ST_DONE)
  - default ADDR_W and DWELL_W constants
  - direction constants DIR_UP=0, DIR_DOWN=1
- One sub-module, dwell_timer:
  - DWELL_W-bit down-counter with load, load value, enable and a zero flag.
  - Instantiated once.
- Address/FSM logic stays in seq_addr_counter.

Test Plan:
1. R=0 mid-RUN at address 2 -> same cycle, asynchronously: SEQFPGA=0, valid=0, step=0, tc=0. After R=1, block stays IDLE until start.
2. limit=3, dwell=2, dir=0, E=1, start pulse -> SEQFPGA 0,0,1,1,2,2,3,3 with valid=1 (8 cycles); step pulses at cycles 1,3,5,7. Then DONE: tc=1 sticky, valid=0, SEQFPGA=3.
3. limit=5, dwell=1, dir=1 -> SEQFPGA 5,4,3,2,1,0 (6 cycles, step every cycle), then tc=1. Then start with limit=1, dir=0 -> tc=0 next cycle, SEQFPGA 0,1.
4. limit=3, dwell=2, E forced 0 for 3 cycles while SEQFPGA=2 -> address and timer frozen, no step. RUN lasts 11 cycles; final sequence is otherwise unchanged.
5. dwell=0, limit=0 -> SEQFPGA=0 valid for exactly 1 cycle with step=1, then tc=1. Also: start asserted during RUN -> no restart; sequence completes unchanged.
6. WRAP_MODE=1, limit=2, dwell=1 -> SEQFPGA 0,1,2,0,1,2,0...; valid stays 1. tc is a one-cycle pulse coincident with each return to 0 (not at the initial 0).
